// File: rtl/vend_change_dispenser_if.sv
// vend_change_dispenser_if: purchase request, coin tube status, ejector handshake and status bundle.
interface vend_change_dispenser_if;
  logic       start_i;
  logic [3:0] credit_i;
  logic [3:0] price_i;
  logic       tube1e_empty_i;
  logic       tube50_empty_i;
  logic       coin_ack_i;
  logic       clear_i;
  logic       busy_o;
  logic       vend_o;
  logic       eject1e_o;
  logic       eject50_o;
  logic       done_o;
  logic       fault_o;
  logic [3:0] change_left_o;
  modport slave (
    input  start_i, credit_i, price_i, tube1e_empty_i, tube50_empty_i, coin_ack_i, clear_i,
    output busy_o, vend_o, eject1e_o, eject50_o, done_o, fault_o, change_left_o
  );
  modport master (
    output start_i, credit_i, price_i, tube1e_empty_i, tube50_empty_i, coin_ack_i, clear_i,
    input  busy_o, vend_o, eject1e_o, eject50_o, done_o, fault_o, change_left_o
  );
endinterface

// File: rtl/vend_change_dispenser.sv
// vend_change_dispenser: vends when credit covers price, then pays change in 1-euro/50-cent coins
// through a four-phase ejector handshake with per-edge timeout.
module vend_change_dispenser #(
  parameter int ACK_TIMEOUT = 200
) (
  input logic                    clk,
  input logic                    rst_n,
  vend_change_dispenser_if.slave vif
);
  typedef enum logic [2:0] {IDLE, CHECK, VEND, PAYOUT, WAIT_ACK, RELEASE, DONE, FAULT} state_t;
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);
  state_t     r_state, w_next;
  logic [3:0] r_rem, w_rem, r_price, w_price;
  logic       r_sel, w_sel;
  logic [7:0] r_cnt, w_cnt;
  logic       w_timeout, w_in_hs;
  assign w_timeout = r_cnt == TO_LAST;
  assign w_in_hs   = r_state == WAIT_ACK || r_state == RELEASE;
  // r_rem holds the credit until CHECK turns it into the amount still owed
  always_comb begin
    w_next  = r_state;
    w_rem   = r_rem;
    w_price = r_price;
    w_sel   = r_sel;
    case (r_state)
      IDLE: if (vif.start_i) begin
        w_next  = CHECK;
        w_rem   = vif.credit_i;
        w_price = vif.price_i;
      end
      CHECK: begin
        w_next = (r_rem >= r_price) ? VEND : PAYOUT;
        w_rem  = (r_rem >= r_price) ? r_rem - r_price : r_rem;
      end
      VEND: w_next = PAYOUT;
      PAYOUT: if (r_rem == 4'd0) w_next = DONE;
        else if (!vif.coin_ack_i) begin
          w_sel  = r_rem >= 4'd2 && !vif.tube1e_empty_i;
          w_next = (w_sel || !vif.tube50_empty_i) ? WAIT_ACK : FAULT;
        end
      WAIT_ACK: if (vif.coin_ack_i) begin
        w_next = RELEASE;
        w_rem  = r_rem - (r_sel ? 4'd2 : 4'd1);
      end else if (w_timeout) w_next = FAULT;
      RELEASE: if (!vif.coin_ack_i) w_next = PAYOUT;
        else if (w_timeout) w_next = FAULT;
      DONE: w_next = IDLE;
      FAULT: if (vif.clear_i) begin
        w_next = IDLE;
        w_rem  = 4'd0;
      end
      default: w_next = IDLE;
    endcase
    w_cnt = (w_next != r_state) ? 8'd0 : (w_in_hs ? r_cnt + 8'd1 : r_cnt);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_rem   <= 4'd0;
      r_price <= 4'd0;
      r_sel   <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next;
      r_rem   <= w_rem;
      r_price <= w_price;
      r_sel   <= w_sel;
      r_cnt   <= w_cnt;
    end
  assign vif.busy_o        = r_state != IDLE;
  assign vif.vend_o        = r_state == VEND;
  assign vif.eject1e_o     = r_state == WAIT_ACK && r_sel;
  assign vif.eject50_o     = r_state == WAIT_ACK && !r_sel;
  assign vif.done_o        = r_state == DONE;
  assign vif.fault_o       = r_state == FAULT;
  assign vif.change_left_o = r_rem;
endmodule
